// File: rtl/clk_rst_seq.sv
// clk_rst_seq: power-up and recovery sequencer for the board MMCM.
//
// Pulses the MMCM reset, waits for a filtered lock indication and then
// releases the downstream reset lines one by one in index order. If lock is
// lost after the first release, every downstream reset is re-asserted, the
// event is counted and the whole sequence starts again. Runs on a free-running
// clock that does not come from the MMCM.
//
// Optional feature (macro CLK_RST_SEQ_TIMEOUT_EN):
//   defined     - WAIT_LOCK gives up after LOCK_TIMEOUT cycles, counts the
//                 timeout in err_cnt and re-pulses the MMCM reset.
//   not defined - WAIT_LOCK waits forever; no timeout counter is built.
//
// Ports:
//   clk        in   free-running reference clock
//   rst        in   asynchronous active-high reset
//   locked     in   MMCM lock status, asynchronous to clk
//   relock_req in   single-cycle request to force a re-lock (honoured in RUN)
//   mmcm_rst   out  reset to the MMCM
//   rst_out    out  NUM_STAGES active-high downstream resets, released in order
//   ready      out  high once every stage has been released
//   err_cnt    out  saturating count of lock losses and timeouts
//   state      out  current state code (0 RST_MMCM, 1 WAIT_LOCK, 2 RELEASE, 3 RUN)

module clk_rst_seq #(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned MMCM_RST_CYCLES = 8,
  parameter int unsigned LOCK_FILTER     = 64,
  parameter int unsigned STAGE_DELAY     = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  relock_req,
  output logic                  mmcm_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            err_cnt,
  output logic [2:0]            state
);

  localparam int unsigned CntMax = 32'h00FF_FFFF;

  // Every count must fit the 24-bit counters and be at least one cycle long.
  if (NUM_STAGES < 1 || NUM_STAGES > CntMax ||
      MMCM_RST_CYCLES < 1 || MMCM_RST_CYCLES > CntMax ||
      LOCK_FILTER < 1 || LOCK_FILTER > CntMax ||
      STAGE_DELAY < 1 || STAGE_DELAY > CntMax ||
      LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > CntMax) begin : g_param_check
    $error("clk_rst_seq: parameter out of range 1..2^24-1");
  end

  // Terminal values: a counter equal to these on an edge completes its interval.
  localparam logic [23:0] RstLast   = 24'(MMCM_RST_CYCLES - 1);
  localparam logic [23:0] FiltLast  = 24'(LOCK_FILTER - 1);
  localparam logic [23:0] StageLast = 24'(STAGE_DELAY - 1);

  typedef enum logic [2:0] {
    StRstMmcm  = 3'd0,
    StWaitLock = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  locked_meta_q, locked_s_q;
  logic [23:0]           cnt_q, cnt_d;    // MMCM reset length, then stage spacing
  logic [23:0]           filt_q, filt_d;  // consecutive cycles of locked_s
  logic                  mmcm_rst_q, mmcm_rst_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  // Decisions taken in the case below, applied after it.
  logic                  filt_hit;
  logic                  stage_step;
  logic                  enter_rst;
  logic                  err_inc;

  // Releases always proceed from bit 0 upwards, so the next release pattern is
  // simply the current one shifted left with a zero fill.
  logic [NUM_STAGES-1:0] rst_out_shl;
  assign rst_out_shl = rst_out_q << 1;

`ifdef CLK_RST_SEQ_TIMEOUT_EN
  localparam logic [23:0] ToLast = 24'(LOCK_TIMEOUT - 1);
  logic [23:0] to_q, to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRstMmcm;
      cnt_q      <= '0;
      filt_q     <= '0;
      mmcm_rst_q <= 1'b1;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      mmcm_rst_q <= mmcm_rst_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    filt_d     = filt_q;
    mmcm_rst_d = mmcm_rst_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    err_cnt_d  = err_cnt_q;
    filt_hit   = 1'b0;
    stage_step = 1'b0;
    enter_rst  = 1'b0;
    err_inc    = 1'b0;
`ifdef CLK_RST_SEQ_TIMEOUT_EN
    to_d       = to_q;
`endif

    unique case (state_q)
      StRstMmcm: begin
        if (cnt_q == RstLast) begin
          state_d    = StWaitLock;
          cnt_d      = '0;
          filt_d     = '0;
          mmcm_rst_d = 1'b0;
`ifdef CLK_RST_SEQ_TIMEOUT_EN
          to_d       = '0;
`endif
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      StWaitLock: begin
        if (locked_s_q) begin
          if (filt_q == FiltLast) begin
            filt_hit   = 1'b1;
            stage_step = 1'b1;
          end else begin
            filt_d = filt_q + 24'd1;
          end
        end else begin
          filt_d = '0;
        end
`ifdef CLK_RST_SEQ_TIMEOUT_EN
        to_d = to_q + 24'd1;
        // A filter completion on the same edge takes precedence.
        if (!filt_hit && (to_q == ToLast)) begin
          err_inc   = 1'b1;
          enter_rst = 1'b1;
        end
`endif
      end

      StRelease: begin
        if (!locked_s_q) begin
          err_inc   = 1'b1;
          enter_rst = 1'b1;
        end else if (cnt_q == StageLast) begin
          stage_step = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end

      StRun: begin
        // Lock loss outranks a simultaneous relock request.
        if (!locked_s_q) begin
          err_inc   = 1'b1;
          enter_rst = 1'b1;
        end else if (relock_req) begin
          enter_rst = 1'b1;
        end
      end

      default: begin
        enter_rst = 1'b1;
      end
    endcase

    // Release the next stage; the last one lands in RUN on the same edge, which
    // also covers a single-stage build leaving WAIT_LOCK straight for RUN.
    if (stage_step) begin
      rst_out_d = rst_out_shl;
      cnt_d     = '0;
      if (rst_out_shl == '0) begin
        state_d = StRun;
        ready_d = 1'b1;
      end else begin
        state_d = StRelease;
      end
    end

    if (enter_rst) begin
      state_d    = StRstMmcm;
      cnt_d      = '0;
      mmcm_rst_d = 1'b1;
      rst_out_d  = '1;
      ready_d    = 1'b0;
    end

    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign mmcm_rst = mmcm_rst_q;
  assign rst_out  = rst_out_q;
  assign ready    = ready_q;
  assign err_cnt  = err_cnt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with NUM_STAGES=4, MMCM_RST_CYCLES=4,
// LOCK_FILTER=8, STAGE_DELAY=5, LOCK_TIMEOUT=100. "Cycle n" is the interval
// after the n-th rising edge following reset release; outputs are sampled and
// inputs driven 1 time unit after each rising edge.

module tb_clk_rst_seq;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       relock_req;
  logic       mmcm_rst;
  logic [3:0] rst_out;
  logic       ready;
  logic [7:0] err_cnt;
  logic [2:0] state;

  int n_checks;
  int n_fail;

  clk_rst_seq #(
    .NUM_STAGES      (4),
    .MMCM_RST_CYCLES (4),
    .LOCK_FILTER     (8),
    .STAGE_DELAY     (5),
    .LOCK_TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .relock_req (relock_req),
    .mmcm_rst   (mmcm_rst),
    .rst_out    (rst_out),
    .ready      (ready),
    .err_cnt    (err_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected rst_out given the number of cycles since rst_out[0] fell
  // (negative: nothing released yet).
  function automatic logic [3:0] exp_rel(input int k);
    if (k < 0)       return 4'hF;
    else if (k < 5)  return 4'hE;
    else if (k < 10) return 4'hC;
    else if (k < 15) return 4'h8;
    else             return 4'h0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst        = 1'b1;
    locked     = 1'b0;
    relock_req = 1'b0;
    repeat (3) next_cycle();
  endtask

  // Releases reset (rst must be high on entry), raises locked in cycle 20 and
  // checks the power-up waveform up to and including cycle `last`.
  task automatic run_power_up(input int last);
    logic [3:0] e_rst;
    logic       e_mmcm, e_ready;
    logic [2:0] e_state;
    next_cycle();
    rst = 1'b0;
    for (int n = 0; n <= last; n++) begin
      if (n > 0) next_cycle();
      if (n == 20) locked = 1'b1;
      e_mmcm  = (n <= 3);
      e_rst   = exp_rel(n - 30);
      e_ready = (n >= 45);
      e_state = (n < 4) ? 3'd0 : (n < 30) ? 3'd1 : (n < 45) ? 3'd2 : 3'd3;
      n_checks += 5;
      if (mmcm_rst !== e_mmcm) begin
        n_fail++; $display("FAIL pwr mmcm_rst n=%0d: got %b expected %b", n, mmcm_rst, e_mmcm);
      end
      if (rst_out !== e_rst) begin
        n_fail++; $display("FAIL pwr rst_out n=%0d: got %h expected %h", n, rst_out, e_rst);
      end
      if (ready !== e_ready) begin
        n_fail++; $display("FAIL pwr ready n=%0d: got %b expected %b", n, ready, e_ready);
      end
      if (state !== e_state) begin
        n_fail++; $display("FAIL pwr state n=%0d: got %0d expected %0d", n, state, e_state);
      end
      if (err_cnt !== 8'd0) begin
        n_fail++; $display("FAIL pwr err_cnt n=%0d: got %0d expected 0", n, err_cnt);
      end
    end
  endtask

  task automatic test_reset();
    hold_reset();
    n_checks += 5;
    if (mmcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL reset mmcm_rst: got %b expected 1", mmcm_rst);
    end
    if (rst_out !== 4'hF) begin
      n_fail++; $display("FAIL reset rst_out: got %h expected f", rst_out);
    end
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset ready: got %b expected 0", ready);
    end
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset err_cnt: got %0d expected 0", err_cnt);
    end
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset state: got %0d expected 0", state);
    end
  endtask

  task automatic test_power_up();
    run_power_up(50);
  endtask

  // Leaves the DUT in RUN with err_cnt = 0.
  task automatic test_glitchy_lock();
    hold_reset();
    next_cycle();
    rst = 1'b0;
    repeat (10) next_cycle();
    for (int k = 0; k <= 35; k++) begin
      if (k > 0) next_cycle();
      if (k <= 18) begin
        n_checks += 2;
        if (rst_out !== ((k < 18) ? 4'hF : 4'hE)) begin
          n_fail++; $display("FAIL glitch rst_out k=%0d: got %h", k, rst_out);
        end
        if (state !== ((k < 18) ? 3'd1 : 3'd2)) begin
          n_fail++; $display("FAIL glitch state k=%0d: got %0d", k, state);
        end
      end
      locked = (k < 5) || (k >= 8);
    end
    n_checks += 3;
    if (rst_out !== 4'h0) begin
      n_fail++; $display("FAIL glitch run rst_out: got %h expected 0", rst_out);
    end
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL glitch run ready: got %b expected 1", ready);
    end
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL glitch run state: got %0d expected 3", state);
    end
  endtask

  task automatic test_lock_loss();
    logic [3:0] e_rst;
    logic       e_mmcm, e_ready;
    logic [2:0] e_state;
    logic [7:0] e_err;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) next_cycle();
      e_rst   = (k <= 2) ? 4'h0 : exp_rel(k - 15);
      e_mmcm  = (k >= 3) && (k <= 6);
      e_ready = (k <= 2) || (k >= 30);
      e_state = (k <= 2) ? 3'd3 : (k <= 6) ? 3'd0 : (k <= 14) ? 3'd1 : (k < 30) ? 3'd2 : 3'd3;
      e_err   = (k >= 3) ? 8'd1 : 8'd0;
      n_checks += 5;
      if (rst_out !== e_rst) begin
        n_fail++; $display("FAIL loss rst_out k=%0d: got %h expected %h", k, rst_out, e_rst);
      end
      if (mmcm_rst !== e_mmcm) begin
        n_fail++; $display("FAIL loss mmcm_rst k=%0d: got %b expected %b", k, mmcm_rst, e_mmcm);
      end
      if (ready !== e_ready) begin
        n_fail++; $display("FAIL loss ready k=%0d: got %b expected %b", k, ready, e_ready);
      end
      if (state !== e_state) begin
        n_fail++; $display("FAIL loss state k=%0d: got %0d expected %0d", k, state, e_state);
      end
      if (err_cnt !== e_err) begin
        n_fail++; $display("FAIL loss err_cnt k=%0d: got %0d expected %0d", k, err_cnt, e_err);
      end
      locked = (k != 0);
    end
  endtask

  // Starts in RUN with err_cnt = 1; the second request lands in WAIT_LOCK.
  task automatic test_relock_req();
    logic [3:0] e_rst;
    logic       e_mmcm, e_ready;
    logic [2:0] e_state;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) next_cycle();
      e_rst   = (k == 0) ? 4'h0 : exp_rel(k - 13);
      e_mmcm  = (k >= 1) && (k <= 4);
      e_ready = (k == 0) || (k >= 28);
      e_state = (k == 0) ? 3'd3 : (k <= 4) ? 3'd0 : (k <= 12) ? 3'd1 : (k < 28) ? 3'd2 : 3'd3;
      n_checks += 5;
      if (rst_out !== e_rst) begin
        n_fail++; $display("FAIL relock rst_out k=%0d: got %h expected %h", k, rst_out, e_rst);
      end
      if (mmcm_rst !== e_mmcm) begin
        n_fail++; $display("FAIL relock mmcm_rst k=%0d: got %b expected %b", k, mmcm_rst, e_mmcm);
      end
      if (ready !== e_ready) begin
        n_fail++; $display("FAIL relock ready k=%0d: got %b expected %b", k, ready, e_ready);
      end
      if (state !== e_state) begin
        n_fail++; $display("FAIL relock state k=%0d: got %0d expected %0d", k, state, e_state);
      end
      if (err_cnt !== 8'd1) begin
        n_fail++; $display("FAIL relock err_cnt k=%0d: got %0d expected 1", k, err_cnt);
      end
      relock_req = (k == 0) || (k == 7);
    end
  endtask

  task automatic check_async_reset(input string tag);
    n_checks += 5;
    if (mmcm_rst !== 1'b1) begin
      n_fail++; $display("FAIL %s mmcm_rst: got %b expected 1", tag, mmcm_rst);
    end
    if (rst_out !== 4'hF) begin
      n_fail++; $display("FAIL %s rst_out: got %h expected f", tag, rst_out);
    end
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL %s ready: got %b expected 0", tag, ready);
    end
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL %s err_cnt: got %0d expected 0", tag, err_cnt);
    end
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL %s state: got %0d expected 0", tag, state);
    end
  endtask

  // Starts in RUN with err_cnt = 1; both reset assertions fall between edges.
  task automatic test_async_reset();
    #3;
    rst    = 1'b1;
    locked = 1'b0;
    #1;
    check_async_reset("async_run");
    repeat (2) next_cycle();
    run_power_up(37);
    #3;
    rst    = 1'b1;
    locked = 1'b0;
    #1;
    check_async_reset("async_release");
    repeat (2) next_cycle();
    check_async_reset("async_hold");
    run_power_up(50);
  endtask

  task automatic test_timeout();
    logic       e_mmcm;
    logic [7:0] e_err;
    hold_reset();
    next_cycle();
    rst = 1'b0;
`ifdef CLK_RST_SEQ_TIMEOUT_EN
    for (int n = 0; n <= 104 * 258; n++) begin
      if (n > 0) next_cycle();
      e_mmcm = ((n % 104) < 4);
      e_err  = ((n / 104) > 255) ? 8'd255 : 8'(n / 104);
      n_checks += 2;
      if (mmcm_rst !== e_mmcm) begin
        n_fail++; $display("FAIL timeout mmcm_rst n=%0d: got %b expected %b", n, mmcm_rst, e_mmcm);
      end
      if (err_cnt !== e_err) begin
        n_fail++; $display("FAIL timeout err_cnt n=%0d: got %0d expected %0d", n, err_cnt, e_err);
      end
    end
`else
    for (int n = 0; n <= 320; n++) begin
      if (n > 0) next_cycle();
      e_mmcm = (n <= 3);
      e_err  = 8'd0;
      n_checks += 3;
      if (mmcm_rst !== e_mmcm) begin
        n_fail++; $display("FAIL nowait mmcm_rst n=%0d: got %b expected %b", n, mmcm_rst, e_mmcm);
      end
      if (err_cnt !== e_err) begin
        n_fail++; $display("FAIL nowait err_cnt n=%0d: got %0d expected 0", n, err_cnt);
      end
      if (state !== ((n < 4) ? 3'd0 : 3'd1)) begin
        n_fail++; $display("FAIL nowait state n=%0d: got %0d", n, state);
      end
    end
`endif
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    locked     = 1'b0;
    relock_req = 1'b0;
    test_reset();
    test_power_up();
    test_glitchy_lock();
    test_lock_loss();
    test_relock_req();
    test_async_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
